usb_in_arbiter: RTL and testbench

Shares one usb2_ep IN endpoint buffer (EP1 IN) between NREQ packet producers, for example jcmd reply generators and status/interrupt reporters inside joker_control.
- Selects one pending requester round-robin.
- Copies that requester's packet from its local buffer into the endpoint buffer.
- Commits the packet and waits for the endpoint's commit handshake.
- Signals completion back to the requester.

---
 rtl/usb_in_arbiter.sv | 150 +++++++++++++++
 tb/tb_usb_in_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter that copies one requester's packet into the shared
// EP1 IN endpoint buffer, commits it, and pulses done back to that requester.
module usb_in_arbiter #(
  parameter int NREQ    = 2,
  parameter int MAX_LEN = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*11-1:0] req_len,
  output logic [NREQ-1:0]   grant,
  output logic [10:0]       rd_addr,
  input  logic [NREQ*8-1:0] rd_data,
  output logic [NREQ-1:0]   done,
  output logic [10:0]       usb_in_addr,
  output logic [7:0]        usb_in_data,
  output logic              usb_in_wren,
  input  logic              usb_in_ready,
  output logic              usb_in_commit,
  output logic [10:0]       usb_in_commit_len,
  input  logic              usb_in_commit_ack
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [10:0]   MAX_LEN_W = 11'(MAX_LEN);
  localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_COMMIT,
    S_ACK_LOW
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [IW-1:0]   r_last;
  logic [10:0]     r_len;
  logic [10:0]     r_rd_addr;
  logic [10:0]     r_wr_addr;
  logic [10:0]     r_commit_len;
  logic            r_rd_pend;
  logic            r_wren;
  logic            r_commit;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [NREQ-1:0] w_onehot;
  logic [10:0]     w_req_len;
  logic [10:0]     w_len;
  logic [7:0]      w_rd_byte;

  // Two ascending passes: first the indices above r_last, then wrap to 0..r_last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!w_found && req[j] && (j > 32'(r_last))) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!w_found && req[j] && (j <= 32'(r_last))) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end
    end
  end

  always_comb begin
    w_onehot  = '0;
    w_req_len = '0;
    w_rd_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_onehot[i] = (w_win == IW'(i));
      if (w_win == IW'(i)) w_req_len = req_len[11*i +: 11];
      if (r_grant[i])      w_rd_byte = rd_data[8*i +: 8];
    end
    w_len = (w_req_len > MAX_LEN_W) ? MAX_LEN_W : w_req_len;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_done       <= '0;
      r_last       <= LAST_RST;
      r_len        <= '0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_commit_len <= '0;
      r_rd_pend    <= 1'b0;
      r_wren       <= 1'b0;
      r_commit     <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          // Skip the done cycle so a requester still holding req is not re-served.
          if (usb_in_ready && (req != '0) && (r_done == '0)) begin
            r_grant   <= w_onehot;
            r_last    <= w_win;
            r_len     <= w_len;
            r_rd_addr <= '0;
            r_rd_pend <= (w_len != '0);
            r_state   <= S_COPY;
          end
        end
        S_COPY: begin
          r_wren    <= r_rd_pend;
          r_wr_addr <= r_rd_addr;
          if (r_rd_pend) begin
            if (r_rd_addr == r_len - 11'd1) r_rd_pend <= 1'b0;
            else                            r_rd_addr <= r_rd_addr + 11'd1;
          end else begin
            r_commit     <= 1'b1;
            r_commit_len <= r_len;
            r_state      <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (usb_in_commit_ack) begin
            r_commit <= 1'b0;
            r_state  <= S_ACK_LOW;
          end
        end
        S_ACK_LOW: begin
          if (!usb_in_commit_ack) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Requester buffers return data one cycle after rd_addr, aligned with r_wr_addr.
  assign usb_in_data       = r_wren ? w_rd_byte : '0;
  assign grant             = r_grant;
  assign done              = r_done;
  assign rd_addr           = r_rd_addr;
  assign usb_in_addr       = r_wr_addr;
  assign usb_in_wren       = r_wren;
  assign usb_in_commit     = r_commit;
  assign usb_in_commit_len = r_commit_len;

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Directed bench for usb_in_arbiter: two requesters with synchronous buffers,
// an endpoint model that logs writes and acknowledges commits after a delay.
module tb_usb_in_arbiter;
  localparam int NREQ    = 2;
  localparam int MAX_LEN = 512;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*11-1:0]  req_len = '0;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic [10:0]         rd_addr;
  logic [NREQ*8-1:0]   rd_data;
  logic [10:0]         usb_in_addr;
  logic [7:0]          usb_in_data;
  logic                usb_in_wren;
  logic                usb_in_ready = 1'b1;
  logic                usb_in_commit;
  logic [10:0]         usb_in_commit_len;
  logic                usb_in_commit_ack = 1'b0;

  always #5 clk = ~clk;

  usb_in_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req               (req),
    .req_len           (req_len),
    .grant             (grant),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .done              (done),
    .usb_in_addr       (usb_in_addr),
    .usb_in_data       (usb_in_data),
    .usb_in_wren       (usb_in_wren),
    .usb_in_ready      (usb_in_ready),
    .usb_in_commit     (usb_in_commit),
    .usb_in_commit_len (usb_in_commit_len),
    .usb_in_commit_ack (usb_in_commit_ack)
  );

  logic [7:0] mem0 [0:1023];
  logic [7:0] mem1 [0:1023];
  logic [7:0] rd0 = '0;
  logic [7:0] rd1 = '0;
  always @(posedge clk) begin
    rd0 <= mem0[rd_addr[9:0]];
    rd1 <= mem1[rd_addr[9:0]];
  end
  assign rd_data = {rd1, rd0};

  // Endpoint model: ack rises after ack_delay commit-high cycles, falls when commit drops.
  int ack_delay = 1;
  int ack_wait  = 0;
  always @(negedge clk) begin
    if (usb_in_commit) begin
      ack_wait = ack_wait + 1;
      if (ack_wait > ack_delay) usb_in_commit_ack = 1'b1;
    end else begin
      ack_wait          = 0;
      usb_in_commit_ack = 1'b0;
    end
  end

  logic [7:0]  ep_mem [0:2047];
  logic [10:0] exp_addr = '0;
  logic        prev_wren = 1'b0;
  logic        prev_commit = 1'b0;
  int wr_total = 0, bursts = 0, addr_err = 0, commits = 0;
  int commit_run = 0, last_commit_run = 0, done_pulses = 0, done_bad = 0;
  logic [10:0] last_commit_len = '0;
  always @(negedge clk) begin
    if (usb_in_wren) begin
      if (!prev_wren) begin
        bursts   = bursts + 1;
        exp_addr = '0;
      end
      if (usb_in_addr != exp_addr) addr_err = addr_err + 1;
      exp_addr            = exp_addr + 11'd1;
      ep_mem[usb_in_addr] = usb_in_data;
      wr_total            = wr_total + 1;
    end
    prev_wren = usb_in_wren;
    if (usb_in_commit) begin
      if (!prev_commit) commits = commits + 1;
      commit_run      = commit_run + 1;
      last_commit_len = usb_in_commit_len;
    end else if (prev_commit) begin
      last_commit_run = commit_run;
      commit_run      = 0;
    end
    prev_commit = usb_in_commit;
    if (done != '0) begin
      done_pulses = done_pulses + 1;
      if (grant != '0 || usb_in_commit_ack) done_bad = done_bad + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp, input int budget);
    int k = 0;
    while (grant == '0 && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(grant), 64'(exp));
  endtask

  task automatic wait_done(input string tag, input logic [NREQ-1:0] exp, input int budget,
                           output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (done == '0 && cycles < budget);
    chk(tag, 64'(done), 64'(exp));
  endtask

  int w0, b0, a0, c0, p0, db0, cyc, gcnt, k;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    tick(3);
    chk("rst_ctrl", 64'({grant, done, usb_in_wren, usb_in_commit}), 64'd0);
    chk("rst_data", 64'({rd_addr, usb_in_addr, usb_in_data, usb_in_commit_len}), 64'd0);
    reset_n = 1'b1;

    // Single 3-byte packet from requester 0
    mem0[0] = 8'h0a; mem0[1] = 8'h00; mem0[2] = 8'h18;
    req_len[10:0] = 11'd3;
    w0 = wr_total; b0 = bursts; a0 = addr_err; p0 = done_pulses;
    req = 2'b01;
    tick(1);
    chk("t1_grant", 64'(grant), 64'(2'b01));
    wait_done("t1_done", 2'b01, 100, cyc);
    req = 2'b00;
    chk("t1_latency", 64'(cyc), 64'd7);
    chk("t1_grant_off", 64'(grant), 64'd0);
    chk("t1_writes", 64'(wr_total - w0), 64'd3);
    chk("t1_bursts", 64'(bursts - b0), 64'd1);
    chk("t1_addr_seq", 64'(addr_err - a0), 64'd0);
    chk("t1_data", 64'({ep_mem[0], ep_mem[1], ep_mem[2]}), 64'h0a0018);
    chk("t1_clen", 64'(last_commit_len), 64'd3);
    tick(1);
    chk("t1_done_once", 64'(done_pulses - p0), 64'd1);

    // Simultaneous requests from reset: 0, then 1, then 0 again
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    mem0[0] = 8'h11; mem0[1] = 8'h22;
    mem1[0] = 8'ha1; mem1[1] = 8'hb2; mem1[2] = 8'hc3; mem1[3] = 8'hd4;
    req_len = {11'd4, 11'd2};
    req = 2'b11;
    tick(1);
    chk("t2_grant1", 64'(grant), 64'(2'b01));
    wait_done("t2_done1", 2'b01, 100, cyc);
    chk("t2_clen1", 64'(last_commit_len), 64'd2);
    chk("t2_data1", 64'({ep_mem[0], ep_mem[1]}), 64'h1122);
    wait_grant("t2_grant2", 2'b10, 5);
    wait_done("t2_done2", 2'b10, 100, cyc);
    chk("t2_clen2", 64'(last_commit_len), 64'd4);
    chk("t2_data2", 64'({ep_mem[0], ep_mem[1], ep_mem[2], ep_mem[3]}), 64'ha1b2c3d4);
    wait_grant("t2_grant3", 2'b01, 5);
    wait_done("t2_done3", 2'b01, 100, cyc);
    req = 2'b00;

    // Zero-length packet
    tick(2);
    req_len[10:0] = 11'd0;
    w0 = wr_total; c0 = commits;
    req = 2'b01;
    wait_grant("t3_grant", 2'b01, 5);
    wait_done("t3_done", 2'b01, 50, cyc);
    req = 2'b00;
    chk("t3_latency", 64'(cyc), 64'd4);
    chk("t3_writes", 64'(wr_total - w0), 64'd0);
    chk("t3_commits", 64'(commits - c0), 64'd1);
    chk("t3_clen", 64'(last_commit_len), 64'd0);

    // Endpoint busy, then slow ack
    tick(2);
    usb_in_ready = 1'b0;
    mem0[0] = 8'h5a; mem0[1] = 8'ha5;
    req_len[10:0] = 11'd2;
    w0 = wr_total; db0 = done_bad;
    req = 2'b01;
    gcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (grant != '0) gcnt++;
    end
    chk("t4_busy_grant", 64'(gcnt), 64'd0);
    ack_delay = 10;
    usb_in_ready = 1'b1;
    tick(1);
    chk("t4_grant", 64'(grant), 64'(2'b01));
    wait_done("t4_done", 2'b01, 100, cyc);
    req = 2'b00;
    chk("t4_commit_run", 64'(last_commit_run), 64'd11);
    chk("t4_done_after_ack", 64'(done_bad - db0), 64'd0);
    chk("t4_writes", 64'(wr_total - w0), 64'd2);
    chk("t4_data", 64'({ep_mem[0], ep_mem[1]}), 64'h5aa5);
    ack_delay = 1;

    // Length clamp
    tick(2);
    for (int i = 0; i < 1024; i++) mem0[i] = 8'(i) ^ 8'h5c;
    req_len[10:0] = 11'd700;
    w0 = wr_total; b0 = bursts; a0 = addr_err;
    req = 2'b01;
    wait_grant("t5_grant", 2'b01, 5);
    wait_done("t5_done", 2'b01, 2000, cyc);
    req = 2'b00;
    chk("t5_writes", 64'(wr_total - w0), 64'd512);
    chk("t5_bursts", 64'(bursts - b0), 64'd1);
    chk("t5_addr_seq", 64'(addr_err - a0), 64'd0);
    chk("t5_clen", 64'(last_commit_len), 64'd512);
    chk("t5_latency", 64'(cyc), 64'd516);
    chk("t5_data", 64'({ep_mem[0], ep_mem[300], ep_mem[511]}), 64'h5c70a3);

    // Reset in the middle of a copy
    tick(2);
    req_len[10:0] = 11'd10;
    c0 = commits; p0 = done_pulses;
    req = 2'b01;
    wait_grant("t6_grant", 2'b01, 5);
    k = 0;
    while (!(usb_in_wren && usb_in_addr == 11'd5) && k < 30) begin
      tick(1);
      k++;
    end
    chk("t6_at_byte5", 64'(usb_in_addr), 64'd5);
    reset_n = 1'b0;
    req = 2'b00;
    tick(1);
    chk("t6_rst_ctrl", 64'({grant, done, usb_in_wren, usb_in_commit}), 64'd0);
    chk("t6_rst_data", 64'({rd_addr, usb_in_addr, usb_in_data, usb_in_commit_len}), 64'd0);
    reset_n = 1'b1;
    req_len[21:11] = 11'd3;
    req = 2'b10;
    tick(1);
    chk("t6_grant1", 64'(grant), 64'(2'b10));
    chk("t6_no_commit", 64'(commits - c0), 64'd0);
    chk("t6_no_done", 64'(done_pulses - p0), 64'd0);
    wait_done("t6_done1", 2'b10, 100, cyc);
    req = 2'b00;
    chk("t6_data1", 64'({ep_mem[0], ep_mem[1], ep_mem[2]}), 64'ha1b2c3);

    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    req = 2'b11;
    tick(1);
    chk("t6_grant_both", 64'(grant), 64'(2'b01));
    wait_done("t6_done_both", 2'b01, 100, cyc);
    req = 2'b00;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
